// File: rtl/fill_cmd_dispatch_if.sv
// Fill command dispatch bus: CPU command write side plus frame filler handshake.
interface fill_cmd_dispatch_if;
  // CPU command write port
  logic        cmd_wr_en;
  logic [23:0] cmd_color;
  logic [31:0] cmd_frame_base;
  logic        cmd_full;
  logic        cmd_overflow;
  // Frame filler request port
  logic        ff_valid;
  logic [23:0] ff_color;
  logic [31:0] ff_frame_base;
  logic        ff_ready;
  // Status
  logic        busy;
  logic [15:0] fills_done;

  // Dispatcher side
  modport slave (
    input  cmd_wr_en,
    input  cmd_color,
    input  cmd_frame_base,
    input  ff_ready,
    output cmd_full,
    output cmd_overflow,
    output ff_valid,
    output ff_color,
    output ff_frame_base,
    output busy,
    output fills_done
  );

  // CPU / filler side
  modport master (
    output cmd_wr_en,
    output cmd_color,
    output cmd_frame_base,
    output ff_ready,
    input  cmd_full,
    input  cmd_overflow,
    input  ff_valid,
    input  ff_color,
    input  ff_frame_base,
    input  busy,
    input  fills_done
  );
endinterface

// File: rtl/fill_cmd_dispatch.sv
// Fill command dispatcher: queues CPU fill commands and hands them one at a
// time to the frame filler, counting completed fills.
module fill_cmd_dispatch #(
  parameter int unsigned DEPTH = 4  // power of two, >= 2
) (
  input  logic              clk,
  input  logic              rst,
  fill_cmd_dispatch_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = 16;

  typedef struct packed {
    logic [31:0] frame_base;
    logic [23:0] color;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q;
  logic            ff_valid_q;
  logic [23:0]     ff_color_q;
  logic [31:0]     ff_frame_base_q;
  logic [FW-1:0]   fills_done_q;
  logic            overflow_q;

  logic            full_c;
  logic            push_c;
  logic            pop_c;
  cmd_t            wr_cmd_c;
  cmd_t            head_c;

  // Full is decoded from registered occupancy, so a write in the same cycle
  // as a pop from a full queue is still dropped.
  assign full_c   = (count_q == CW'(DEPTH));
  assign push_c   = bus.cmd_wr_en && !full_c;
  assign pop_c    = (state_q == ST_IDLE) && (count_q != '0) && bus.ff_ready;
  assign wr_cmd_c = '{frame_base: bus.cmd_frame_base, color: bus.cmd_color};
  assign head_c   = mem_q[rd_ptr_q];

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_cmd_c;
    end
  end

  // Sticky overflow: any write that finds the queue full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (bus.cmd_wr_en && full_c) begin
      overflow_q <= 1'b1;
    end
  end

  // Dispatch FSM: present head entry, wait for filler to take it, then for it to finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ff_valid_q      <= 1'b0;
      ff_color_q      <= '0;
      ff_frame_base_q <= '0;
      fills_done_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop_c) begin
            state_q         <= ST_ISSUE;
            ff_valid_q      <= 1'b1;
            ff_color_q      <= head_c.color;
            ff_frame_base_q <= head_c.frame_base;
          end
        end
        ST_ISSUE: begin
          // Filler drops ready when it starts working on the request.
          if (!bus.ff_ready) begin
            state_q    <= ST_WAIT_DONE;
            ff_valid_q <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.ff_ready) begin
            state_q      <= ST_IDLE;
            fills_done_q <= fills_done_q + FW'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ff_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_full      = full_c;
  assign bus.cmd_overflow  = overflow_q;
  assign bus.ff_valid      = ff_valid_q;
  assign bus.ff_color      = ff_color_q;
  assign bus.ff_frame_base = ff_frame_base_q;
  assign bus.busy          = (count_q != '0) || (state_q != ST_IDLE);
  assign bus.fills_done    = fills_done_q;

endmodule

// File: tb/tb_fill_cmd_dispatch.sv
// Bench for fill_cmd_dispatch: transaction-level reference model plus an
// issue-order scoreboard checked by an independent monitor.
module tb_fill_cmd_dispatch;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fill_cmd_dispatch_if bus();

  fill_cmd_dispatch #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] color;
    logic [31:0] base;
  } cmd_t;

  // Reference model: queued commands, fill phase (0 none, 1 offered, 2 being filled)
  cmd_t        mq[$];
  cmd_t        exp_q[$];
  int          m_ph;
  bit          m_ovf;
  logic [15:0] m_done;
  logic [23:0] m_col;
  logic [31:0] m_base;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ph   = 0;
    m_ovf  = 1'b0;
    m_done = '0;
    m_col  = '0;
    m_base = '0;
  endtask

  task automatic check_model();
    chk("ff_valid",      64'(bus.ff_valid),      64'(m_ph == 1));
    chk("cmd_full",      64'(bus.cmd_full),      64'(mq.size() == int'(DEPTH)));
    chk("busy",          64'(bus.busy),          64'(mq.size() != 0 || m_ph != 0));
    chk("cmd_overflow",  64'(bus.cmd_overflow),  64'(m_ovf));
    chk("fills_done",    64'(bus.fills_done),    64'(m_done));
    chk("ff_color",      64'(bus.ff_color),      64'(m_col));
    chk("ff_frame_base", 64'(bus.ff_frame_base), 64'(m_base));
    chk("occupancy",     64'(dut.count_q),       64'(mq.size()));
  endtask

  // Apply one cycle of inputs, advance the model over the coming edge, check after it.
  task automatic step(input bit wr, input logic [23:0] c, input logic [31:0] b, input bit rdy);
    bit   full;
    cmd_t it;
    bus.cmd_wr_en      = wr;
    bus.cmd_color      = c;
    bus.cmd_frame_base = b;
    bus.ff_ready       = rdy;
    full = (mq.size() == int'(DEPTH));
    if (wr && full) m_ovf = 1'b1;
    if (m_ph == 0 && mq.size() > 0 && rdy) begin
      it     = mq.pop_front();
      m_col  = it.color;
      m_base = it.base;
      m_ph   = 1;
    end else if (m_ph == 1 && !rdy) begin
      m_ph = 2;
    end else if (m_ph == 2 && rdy) begin
      m_ph   = 0;
      m_done = m_done + 16'd1;
    end
    if (wr && !full) begin
      it.color = c;
      it.base  = b;
      mq.push_back(it);
      exp_q.push_back(it);
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic bit filler_rdy();
    case (m_ph)
      1:       return $urandom_range(0, 2) == 0;
      2:       return $urandom_range(0, 1) == 1;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while ((mq.size() != 0 || m_ph != 0) && n < max) begin
      step(1'b0, '0, '0, filler_rdy());
      n++;
    end
    if (mq.size() != 0 || m_ph != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: still busy after %0d cycles, %0d queued", n, mq.size());
    end
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    bus.cmd_wr_en = 1'b0;
    bus.ff_ready  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_valid", 64'(bus.ff_valid), 64'(0));
    chk("rst_async_busy",  64'(bus.busy),     64'(0));
    chk("rst_async_occ",   64'(dut.count_q),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    check_model();
  endtask

  // Monitor: every new request must match the oldest accepted command, and hold steady.
  initial begin : monitor
    bit          prev;
    logic [23:0] hc;
    logic [31:0] hb;
    cmd_t        e;
    prev = 1'b0;
    hc   = '0;
    hb   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.ff_valid && !prev) begin
          if (exp_q.size() == 0) begin
            chk("issue_pending", 64'(exp_q.size()), 64'(1));
          end else begin
            e = exp_q.pop_front();
            chk("issue_color", 64'(bus.ff_color),      64'(e.color));
            chk("issue_base",  64'(bus.ff_frame_base), 64'(e.base));
            hc = e.color;
            hb = e.base;
          end
        end else if (bus.ff_valid && prev) begin
          chk("hold_color", 64'(bus.ff_color),      64'(hc));
          chk("hold_base",  64'(bus.ff_frame_base), 64'(hb));
        end
        prev = bus.ff_valid;
      end
    end
  end

  initial begin : stimulus
    bus.cmd_wr_en      = 1'b0;
    bus.cmd_color      = '0;
    bus.cmd_frame_base = '0;
    bus.ff_ready       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model();
    rst = 1'b0;
    @(negedge clk);
    check_model();

    // Single fill with minimum latency
    step(1'b1, 24'hFF0000, 32'h1000_0000, 1'b1);
    chk("lat_edge1_valid", 64'(bus.ff_valid), 64'(0));
    step(1'b0, '0, '0, 1'b1);
    chk("lat_edge2_valid", 64'(bus.ff_valid),      64'(1));
    chk("single_color",    64'(bus.ff_color),      64'(24'hFF0000));
    chk("single_base",     64'(bus.ff_frame_base), 64'(32'h1000_0000));
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    chk("single_accept_valid", 64'(bus.ff_valid), 64'(0));
    step(1'b0, '0, '0, 1'b1);
    chk("single_done", 64'(bus.fills_done), 64'(1));
    chk("single_busy", 64'(bus.busy),       64'(0));

    // Fill the queue past capacity, then release in order
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 24'(32'h11_1111 * (i + 1)), 32'h2000_0000 + 32'(i) * 32'h100, 1'b0);
      if (i == 3) chk("full_after_4", 64'(bus.cmd_full), 64'(1));
    end
    chk("overflow_after_5", 64'(bus.cmd_overflow), 64'(1));
    chk("occ_after_5",      64'(dut.count_q),      64'(4));
    drain(200);
    chk("fills_after_release", 64'(bus.fills_done), 64'(4));

    // Filler holds ready high: request and data stay put, no extra pop
    do_reset();
    step(1'b1, 24'h00FF00, 32'h3000_0000, 1'b0);
    step(1'b1, 24'h0000FF, 32'h3000_1000, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1);
    chk("held_occ",   64'(dut.count_q),  64'(1));
    chk("held_valid", 64'(bus.ff_valid), 64'(1));
    drain(200);

    // Write coincides with pop from a full queue: dropped
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 24'(i + 16), 32'h4000_0000 + 32'(i), 1'b0);
    step(1'b1, 24'hABCDEF, 32'hDEAD_BEEF, 1'b1);
    chk("pushpop_occ",      64'(dut.count_q),      64'(3));
    chk("pushpop_overflow", 64'(bus.cmd_overflow), 64'(1));
    chk("pushpop_valid",    64'(bus.ff_valid),     64'(1));
    drain(200);
    chk("pushpop_fills", 64'(bus.fills_done), 64'(4));

    // Reset while the filler is working, with commands still queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 24'(i + 32), 32'h5000_0000 + 32'(i), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    chk("midfill_occ", 64'(dut.count_q), 64'(2));
    do_reset();
    chk("midfill_done_after", 64'(bus.fills_done), 64'(0));
    chk("midfill_busy_after", 64'(bus.busy),       64'(0));

    // Completed-fill counter wrap
    do_reset();
    force dut.fills_done_q = 16'hFFFE;
    #1;
    release dut.fills_done_q;
    m_done = 16'hFFFE;
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 24'h123456, 32'h6000_0000, 1'b0);
    step(1'b1, 24'h654321, 32'h6000_4000, 1'b0);
    drain(200);
    chk("wrap_done", 64'(bus.fills_done), 64'(0));

    // Random traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 1)), 24'($urandom), $urandom, filler_rdy());
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
